// File: rtl/mul_nibble_seq.sv
// Iterative unsigned WxW multiplier: one 4x4 digit product per clock, shifted and
// accumulated into a 2W-bit result, with valid/ready handshakes on both sides.

module Multiplier_4X4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  // Shift-and-add array over the four multiplier bits.
  always_comb begin
    p_o = '0;
    for (int k = 0; k < 4; k++) begin
      if (b_i[k]) p_o = p_o + ({4'b0000, a_i} << k);
    end
  end

endmodule

module mul_nibble_seq #(
  parameter int W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [2*W-1:0]   o_product,
  output logic             o_busy
);

  // state | meaning
  // IDLE  | waiting for operands, o_ready high
  // RUN   | stepping digit pairs (i,j) through the 4x4 array
  // DONE  | result presented on o_product until consumer takes it

  localparam int NIB = W / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int PW  = 2 * W;
  localparam int SHW = $clog2(PW);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  if ((W % 4) != 0) begin : g_width_check
    $error("mul_nibble_seq: W=%0d is not a multiple of 4", W);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   i_q, i_d;
  logic [CW-1:0]   j_q, j_d;

  logic [3:0]      a_nib, b_nib;
  logic [7:0]      pp8;
  logic [SHW-1:0]  digit_sum;
  logic [SHW-1:0]  shamt;
  logic [PW-1:0]   pp_shifted;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int k = 0; k < NIB; k++) begin
      if (i_q == CW'(k)) a_nib = a_q[4*k +: 4];
      if (j_q == CW'(k)) b_nib = b_q[4*k +: 4];
    end
  end

  Multiplier_4X4 u_mul4 (
    .a_i (a_nib),
    .b_i (b_nib),
    .p_o (pp8)
  );

  // Digit weight is 16^(i+j); the largest shift is 2W-8, so nothing falls off the top.
  always_comb begin
    digit_sum  = SHW'(i_q) + SHW'(j_q);
    shamt      = digit_sum << 2;
    pp_shifted = PW'(pp8) << shamt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d   = i_a;
          b_d   = i_b;
          acc_d = '0;
          i_d   = '0;
          j_d   = '0;
          // A zero operand skips the digit loop; the cleared accumulator is the answer.
          if ((i_a == '0) || (i_b == '0)) state_d = DONE;
          else                            state_d = RUN;
        end
      end

      RUN: begin
        acc_d = acc_q + pp_shifted;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end

      DONE: begin
        if (i_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready   = (state_q == IDLE);
    o_valid   = (state_q == DONE);
    o_busy    = (state_q == RUN);
    o_product = acc_q;
  end

endmodule

// File: tb/tb_mul_nibble_seq.sv
// Scoreboard bench for mul_nibble_seq at W=8 and W=24: drivers push expected
// products, per-width monitors pop and compare on every result handshake.

module tb_mul_nibble_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v24_i = 1'b0, rdy24_o, vld24_o, rdy24_i = 1'b1, busy24;
  logic [23:0] a24 = '0, b24 = '0;
  logic [47:0] p24;

  logic        v8_i = 1'b0, rdy8_o, vld8_o, rdy8_i = 1'b1, busy8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;

  mul_nibble_seq #(.W(24)) u_dut24 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v24_i), .o_ready(rdy24_o),
    .i_a(a24), .i_b(b24), .o_valid(vld24_o), .i_ready(rdy24_i),
    .o_product(p24), .o_busy(busy24)
  );

  mul_nibble_seq #(.W(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8_i), .o_ready(rdy8_o),
    .i_a(a8), .i_b(b8), .o_valid(vld8_o), .i_ready(rdy8_i),
    .o_product(p8), .o_busy(busy8)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [47:0] q24[$];
  logic [15:0] q8[$];
  bit stall24 = 1'b0;
  bit rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    rdy24_i = stall24 ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    rdy8_i  = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitors: a handshake at the next edge pops one expectation; a stalled result must hold.
  logic        hold24 = 1'b0, hold8 = 1'b0;
  logic [47:0] held24, e24;
  logic [15:0] held8, e8;

  always @(negedge clk) begin
    if (rst_n && hold24) begin
      chk("hold_valid24", 64'(vld24_o), 64'd1);
      chk("hold_product24", 64'(p24), 64'(held24));
    end
    if (rst_n && vld24_o) begin
      chk("ready_in_done24", 64'(rdy24_o), 64'd0);
      if (rdy24_i) begin
        hold24 = 1'b0;
        if (q24.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected24: result 0x%0h with empty scoreboard", p24);
        end else begin
          e24 = q24.pop_front();
          chk("product24", 64'(p24), 64'(e24));
        end
      end else begin
        hold24 = 1'b1;
        held24 = p24;
      end
    end else begin
      hold24 = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && hold8) begin
      chk("hold_valid8", 64'(vld8_o), 64'd1);
      chk("hold_product8", 64'(p8), 64'(held8));
    end
    if (rst_n && vld8_o) begin
      chk("ready_in_done8", 64'(rdy8_o), 64'd0);
      if (rdy8_i) begin
        hold8 = 1'b0;
        if (q8.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected8: result 0x%0h with empty scoreboard", p8);
        end else begin
          e8 = q8.pop_front();
          chk("product8", 64'(p8), 64'(e8));
        end
      end else begin
        hold8 = 1'b1;
        held8 = p8;
      end
    end else begin
      hold8 = 1'b0;
    end
  end

  // exp_lat: edges from accept to o_valid high (0 = visible right after the accept edge); <0 skips.
  task automatic issue24(input logic [23:0] a, input logic [23:0] b, input logic [47:0] exp,
                         input int exp_lat);
    int n;
    int lat;
    @(posedge clk); #1;
    v24_i = 1'b1; a24 = a; b24 = b;
    n = 0;
    @(negedge clk);
    while (!rdy24_o && n < 200) begin @(negedge clk); n++; end
    if (!rdy24_o) begin
      n_cmp++; n_err++;
      $display("FAIL accept24: o_ready never rose for a=0x%0h b=0x%0h", a, b);
      v24_i = 1'b0;
      return;
    end
    @(posedge clk);
    q24.push_back(exp);
    #1;
    v24_i = 1'b0; a24 = 24'($urandom); b24 = 24'($urandom);
    if (exp_lat >= 0) begin
      lat = 0;
      @(negedge clk);
      while (!vld24_o && lat < 200) begin @(negedge clk); lat++; end
      chk("latency24", 64'(lat), 64'(exp_lat));
    end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input int exp_lat);
    int n;
    int lat;
    @(posedge clk); #1;
    v8_i = 1'b1; a8 = a; b8 = b;
    n = 0;
    @(negedge clk);
    while (!rdy8_o && n < 200) begin @(negedge clk); n++; end
    if (!rdy8_o) begin
      n_cmp++; n_err++;
      $display("FAIL accept8: o_ready never rose for a=0x%0h b=0x%0h", a, b);
      v8_i = 1'b0;
      return;
    end
    @(posedge clk);
    q8.push_back(exp);
    #1;
    v8_i = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    if (exp_lat >= 0) begin
      lat = 0;
      @(negedge clk);
      while (!vld8_o && lat < 200) begin @(negedge clk); lat++; end
      chk("latency8", 64'(lat), 64'(exp_lat));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q24.size() != 0 || q8.size() != 0) && n < 5000) begin @(negedge clk); n++; end
    if (q24.size() != 0 || q8.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d/%0d results never arrived", q24.size(), q8.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ra, rb;
    logic [7:0]  sa, sb;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready24", 64'(rdy24_o), 64'd1);
    chk("rst_valid24", 64'(vld24_o), 64'd0);
    chk("rst_busy24", 64'(busy24), 64'd0);
    chk("rst_product24", 64'(p24), 64'd0);
    chk("rst_ready8", 64'(rdy8_o), 64'd1);
    chk("rst_valid8", 64'(vld8_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue8(8'hFF, 8'hFF, 16'hFE01, 4);
    issue8(8'h12, 8'h34, 16'h03A8, 4);
    issue8(8'h80, 8'h02, 16'h0100, 4);
    issue8(8'h0F, 8'hF0, 16'h0E10, 4);
    issue8(8'h00, 8'h55, 16'h0000, 0);
    drain();

    issue24(24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FE00_0001, 36);
    issue24(24'h800000, 24'h000003, 48'h0000_0180_0000, 36);
    issue24(24'h000000, 24'h123456, 48'h0, 0);
    issue24(24'h000005, 24'h000000, 48'h0, 0);
    issue24(24'h123456, 24'h000002, 48'h0000_0024_68AC, -1);
    issue24(24'h001000, 24'h001000, 48'h0000_0100_0000, -1);
    issue24(24'hABCDEF, 24'h000001, 48'h0000_00AB_CDEF, -1);
    issue24(24'h000100, 24'h00FF00, 48'h0000_00FF_0000, -1);
    issue24(24'h000007, 24'h000009, 48'h0000_0000_003F, -1);
    drain();

    // Backpressure: result must hold and new requests must be refused.
    stall24 = 1'b1;
    issue24(24'h0F0F0F, 24'h000101, 48'h0000_0F1E_1E0F, 36);
    repeat (5) begin
      @(posedge clk); #1;
      v24_i = 1'b1; a24 = 24'($urandom); b24 = 24'h000001;
      @(negedge clk);
      chk("bp_ready24", 64'(rdy24_o), 64'd0);
      chk("bp_valid24", 64'(vld24_o), 64'd1);
    end
    @(posedge clk); #1;
    v24_i = 1'b0;
    @(negedge clk);
    stall24 = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("bp_no_extra24", 64'(vld24_o), 64'd0);

    // Reset in the middle of the digit loop discards the operation.
    issue24(24'hABCDEF, 24'h123456, 48'h0, -1);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_before_abort24", 64'(busy24), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready24", 64'(rdy24_o), 64'd1);
    chk("abort_valid24", 64'(vld24_o), 64'd0);
    chk("abort_busy24", 64'(busy24), 64'd0);
    chk("abort_product24", 64'(p24), 64'd0);
    q24.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue24(24'h000003, 24'h000005, 48'd15, 36);
    drain();

    // Bulk traffic with consumer gaps and occasional zero operands.
    rand_rdy = 1'b1;
    for (int k = 0; k < 150; k++) begin
      sa = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      sb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      issue8(sa, sb, 16'(sa) * 16'(sb), -1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    for (int k = 0; k < 150; k++) begin
      ra = ($urandom_range(0, 15) == 0) ? 24'h0 : 24'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 24'h0 : 24'($urandom);
      issue24(ra, rb, 48'(ra) * 48'(rb), -1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();
    rand_rdy = 1'b0;

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
